imem_loader: RTL and testbench
==============================

# imem_loader

Byte-stream program loader that fills the pipelined MIPS32 instruction/data memory before execution starts. It accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Each completed word is written through a single-port memory write interface. It holds the processor in reset (`cpu_hold`) until a frame with a correct checksum has been fully received, then releases it.

## Interface

Parameters:
- `ADDR_W`, default 6: memory word-address width.
- `BASE_ADDR`, default 0: word address of the first loaded word.
- `MAX_WORDS`, default 51: largest legal word count in a frame (the memory depth).
- `SYNC_BYTE`, default 8'hA5: frame start marker.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input byte valid.
- `in_data`  in  8  input byte.
- `in_ready`  out  1  loader can accept a byte.
- `mem_we`  out  1  memory write strobe, one-cycle pulse per word.
- `mem_addr`  out  ADDR_W  word address for the write.
- `mem_wdata`  out  32  word being written.
- `cpu_hold`  out  1  high keeps the processor stalled/reset.
- `done`  out  1  a load completed successfully (sticky).
- `error`  out  1  the last frame was rejected (sticky until the next sync byte).
- `words_loaded`  out  ADDR_W+1  words written in the current or last frame.

## Operation

- Frame format: `SYNC_BYTE`, count byte N, N×4 data bytes (most significant byte first), checksum byte. The checksum is the XOR of all 4N data bytes.
- A byte transfers on a rising edge where `in_valid && in_ready`. Nothing advances without a transfer.
- States and transitions:
  - IDLE: accepted bytes other than `SYNC_BYTE` are discarded. `SYNC_BYTE` → COUNT.
  - COUNT: N=0 or N>`MAX_WORDS` → ERR. Otherwise latch N, clear `words_loaded`, clear the byte index and the checksum accumulator, → DATA.
  - DATA: shift each byte into the 32-bit assembly register and XOR it into the accumulator. On the 4th byte of a word, issue a write and increment `words_loaded`. After the write of word N → CHECK.
  - CHECK: checksum byte equal to the accumulator → DONE. Not equal → ERR.
  - DONE: terminal until reset. `in_ready`=0, `done`=1, `cpu_hold`=0.
  - ERR: `error`=1, `cpu_hold`=1, `in_ready`=1. Non-sync bytes are discarded. `SYNC_BYTE` clears `error` and → COUNT.
- Write address is `BASE_ADDR + k` for word k (0-based), truncated to ADDR_W bits.
- Words already written are not rolled back on ERR. The processor stays held, so stale contents are never executed.

## Timing

- Reset values: `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=1, `done`=0, `error`=0, `words_loaded`=0, state IDLE.
- `in_ready` goes to 1 in the first cycle after `reset` deasserts. It stays 1 in IDLE, COUNT, DATA, CHECK and ERR.
- Write latency: `mem_we` is high for exactly the one cycle after the edge that accepts the 4th byte of a word. `mem_addr` and `mem_wdata` are valid in that same cycle. `words_loaded` shows the incremented value in that same cycle.
- Back-to-back input at one byte per cycle is sustained. There is no backpressure during DATA.
- Checksum acceptance: one cycle later the state is DONE, `cpu_hold` falls, `done` rises, and `in_ready` falls, all in the same cycle.
- Gaps in `in_valid` at any point hold the state, byte index and accumulator.
- Reset asserted mid-frame: on the next edge all outputs return to reset values and any partial word is discarded. A `mem_we` pulse due on that edge is suppressed.
- Count error: `error` rises on the cycle after the offending count byte is accepted. No write is issued.

## Test plan

- Valid 2-word frame A5 02 28 0A 00 1E FC 00 00 00 C0 streamed one byte per cycle:
  - `mem_we` pulses at addr 0 with 0x280A001E, then at addr 1 with 0xFC000000.
  - `words_loaded`=2, `done`=1, `cpu_hold`=0, `in_ready`=0.
- Same frame with checksum C1: both writes occur, then `error`=1, `cpu_hold`=1, `done`=0. A following correct frame ends with `done`=1 and `error`=0.
- Leading garbage 00 FF 5A, then a valid 1-word frame A5 01 DE AD BE EF 22: the garbage is ignored, one write of 0xDEADBEEF at addr 0, `done`=1.
- Count byte 00, and separately count 52 (with `MAX_WORDS`=51): `error`=1 one cycle after the count byte, no `mem_we`.
- The 2-word frame with `in_valid` dropped for 3 cycles between every byte: identical writes and final outputs as the back-to-back case.
- `reset` pulsed after the 6th byte of the 2-word frame: all outputs at reset values, no write of word 0. A fresh full frame then loads correctly.

Source files
------------

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader for the MIPS32 instruction/data memory
// Assembles big-endian words and holds the CPU until a checksummed frame is complete.
module imem_loader #(
  parameter int         ADDR_W    = 6,
  parameter int         BASE_ADDR = 0,
  parameter int         MAX_WORDS = 51,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);
  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_DATA, S_CHECK, S_DONE, S_ERR} state_t;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t      state;
  logic [7:0]  count;
  logic [7:0]  acc;
  logic [1:0]  idx;
  logic [23:0] shift;  // the fourth byte comes straight from in_data
  logic        xfer;
  logic [31:0] word_next;
  logic        last_word;

  assign xfer      = in_valid && in_ready;
  assign word_next = {shift, in_data};
  assign last_word = (8'(words_loaded) + 8'd1) == count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      count        <= '0;
      acc          <= '0;
      idx          <= '0;
      shift        <= '0;
    end else begin
      mem_we   <= 1'b0;
      in_ready <= (state != S_DONE);
      case (state)
        S_IDLE: begin
          if (xfer && in_data == SYNC_BYTE) state <= S_COUNT;
        end
        S_COUNT: begin
          if (xfer) begin
            if (in_data == 8'd0 || int'(in_data) > MAX_WORDS) begin
              error <= 1'b1;
              state <= S_ERR;
            end else begin
              count        <= in_data;
              words_loaded <= '0;
              idx          <= '0;
              acc          <= '0;
              state        <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            shift <= word_next[23:0];
            acc   <= acc ^ in_data;
            idx   <= idx + 2'd1;
            if (idx == 2'd3) begin
              mem_we       <= 1'b1;
              mem_addr     <= BASE + words_loaded[ADDR_W-1:0];
              mem_wdata    <= word_next;
              words_loaded <= words_loaded + (ADDR_W+1)'(1);
              if (last_word) state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (xfer) begin
            if (in_data == acc) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
              in_ready <= 1'b0;
              state    <= S_DONE;
            end else begin
              error <= 1'b1;
              state <= S_ERR;
            end
          end
        end
        S_DONE: ;
        S_ERR: begin
          // Only a fresh sync byte restarts; everything else is line noise.
          if (xfer && in_data == SYNC_BYTE) begin
            error <= 1'b0;
            state <= S_COUNT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
// A frame-parsing model predicts writes and final status from the whole byte history.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mem_we, cpu_hold, done, error;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [6:0]  words_loaded;

  imem_loader #(.ADDR_W(6), .BASE_ADDR(0), .MAX_WORDS(51), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
    logic [6:0]  wl;
  } wr_t;

  wr_t        exp_w[$];
  logic [7:0] hist[$];
  bit         exp_done, exp_error;
  int         exp_wl;
  int         wr_seen = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  wr_t        cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Parse the byte history since the last reset as a list of frames.
  task automatic model();
    int i;
    int n;
    logic [7:0]  x;
    logic [31:0] word;
    bit ok;
    i = 0;
    exp_w.delete();
    exp_done = 0; exp_error = 0; exp_wl = 0;
    while (i < hist.size() && !exp_done) begin
      if (hist[i] != 8'hA5) begin i++; continue; end
      exp_error = 0; i++;
      if (i >= hist.size()) break;
      n = int'(hist[i]); i++;
      if (n == 0 || n > 51) begin exp_error = 1; continue; end
      exp_wl = 0; x = 8'h00; ok = 1;
      for (int k = 0; k < n; k++) begin
        if (i + 4 > hist.size()) begin ok = 0; break; end
        word = {hist[i], hist[i+1], hist[i+2], hist[i+3]};
        x = x ^ hist[i] ^ hist[i+1] ^ hist[i+2] ^ hist[i+3];
        exp_w.push_back(wr_t'({6'(k), word, 7'(k + 1)}));
        exp_wl = k + 1;
        i += 4;
      end
      if (!ok || i >= hist.size()) break;
      if (hist[i] == x) exp_done = 1; else exp_error = 1;
      i++;
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      if (wr_seen >= exp_w.size()) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write", mem_addr, mem_wdata);
      end else begin
        cur = exp_w[wr_seen];
        chk("write_addr", mem_addr, cur.addr);
        chk("write_data", mem_wdata, cur.data);
        chk("write_words_loaded", words_loaded, cur.wl);
      end
      wr_seen++;
    end
  end

  task automatic check_reset_vals(input string name);
    chk({name, "_in_ready"}, in_ready, 0);
    chk({name, "_mem_we"}, mem_we, 0);
    chk({name, "_mem_addr"}, mem_addr, 0);
    chk({name, "_mem_wdata"}, mem_wdata, 0);
    chk({name, "_cpu_hold"}, cpu_hold, 1);
    chk({name, "_done"}, done, 0);
    chk({name, "_error"}, error, 0);
    chk({name, "_words_loaded"}, words_loaded, 0);
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk); reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    if (check) check_reset_vals("reset");
    @(negedge clk); reset = 1'b0;
    hist.delete(); wr_seen = 0; model();
    @(negedge clk);
    if (check) chk("in_ready_after_reset", in_ready, 1);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    repeat (gap) begin @(negedge clk); in_valid = 1'b0; end
    @(negedge clk); in_valid = 1'b1; in_data = b;
    while (!in_ready && t < 10) begin @(negedge clk); t++; end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL in_ready_timeout: byte %0h not accepted, in_ready %0b expected 1", b, in_ready);
    end
    @(posedge clk);
  endtask

  task automatic run(input logic [7:0] s[$], input int gap);
    foreach (s[i]) hist.push_back(s[i]);
    model();
    foreach (s[i]) send(s[i], (i == 0) ? 0 : gap);
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic final_chk(input string name);
    repeat (3) @(negedge clk);
    chk({name, "_write_count"}, wr_seen, exp_w.size());
    chk({name, "_done"}, done, exp_done);
    chk({name, "_error"}, error, exp_error);
    chk({name, "_cpu_hold"}, cpu_hold, !exp_done);
    chk({name, "_in_ready"}, in_ready, !exp_done);
    chk({name, "_words_loaded"}, words_loaded, exp_wl);
  endtask

  initial begin
    logic [7:0] f2[$];
    logic [7:0] f2bad[$];
    logic [7:0] f1g[$];
    logic [7:0] c0[$];
    logic [7:0] c52[$];
    f2    = '{8'hA5, 8'h02, 8'h28, 8'h0A, 8'h00, 8'h1E, 8'hFC, 8'h00, 8'h00, 8'h00, 8'hC0};
    f2bad = '{8'hA5, 8'h02, 8'h28, 8'h0A, 8'h00, 8'h1E, 8'hFC, 8'h00, 8'h00, 8'h00, 8'hC1};
    f1g   = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    c0    = '{8'hA5, 8'h00};
    c52   = '{8'hA5, 8'h34};

    do_reset(1);

    run(f2, 0);
    chk("t1_model_nwords", exp_w.size(), 2);
    chk("t1_model_w0_addr", exp_w[0].addr, 6'd0);
    chk("t1_model_w0_data", exp_w[0].data, 32'h280A001E);
    chk("t1_model_w1_addr", exp_w[1].addr, 6'd1);
    chk("t1_model_w1_data", exp_w[1].data, 32'hFC000000);
    chk("t1_done_next_cycle", done, 1);
    chk("t1_cpu_hold_next_cycle", cpu_hold, 0);
    chk("t1_in_ready_next_cycle", in_ready, 0);
    final_chk("t1");
    chk("t1_words_loaded_lit", words_loaded, 2);

    do_reset(0);
    run(f2bad, 0);
    chk("t2_error_next_cycle", error, 1);
    chk("t2_done_lit", done, 0);
    chk("t2_cpu_hold_lit", cpu_hold, 1);
    final_chk("t2a");
    run(f2, 0);
    final_chk("t2b");
    chk("t2_total_writes_lit", wr_seen, 4);
    chk("t2_error_cleared_lit", error, 0);

    do_reset(0);
    run(f1g, 0);
    chk("t3_model_data", exp_w[0].data, 32'hDEADBEEF);
    final_chk("t3");
    chk("t3_writes_lit", wr_seen, 1);

    do_reset(0);
    run(c0, 0);
    chk("t4_count0_error_next_cycle", error, 1);
    final_chk("t4a");
    chk("t4_count0_no_write", wr_seen, 0);
    do_reset(0);
    run(c52, 0);
    chk("t4_count52_error_next_cycle", error, 1);
    final_chk("t4b");
    chk("t4_count52_no_write", wr_seen, 0);

    do_reset(0);
    run(f2, 3);
    final_chk("t5");
    chk("t5_done_lit", done, 1);
    chk("t5_writes_lit", wr_seen, 2);

    do_reset(0);
    for (int i = 0; i < 5; i++) send(f2[i], 0);
    @(negedge clk); in_valid = 1'b1; in_data = f2[5]; reset = 1'b1;
    @(negedge clk);
    check_reset_vals("t6_midframe");
    chk("t6_no_write", wr_seen, 0);
    reset = 1'b0; in_valid = 1'b0;
    hist.delete(); wr_seen = 0; model();
    run(f2, 0);
    final_chk("t6");
    chk("t6_done_lit", done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end
endmodule
